// File: rtl/cdma_frame_encoder_pkg.sv
// Shared constants and types for the CDMA crossbar encoder and decoder slices.
package AggrCDMAPkg;

  localparam int DATA_WIDTH      = 8;
  localparam int LOG_CODE_WIDTH  = 2;
  localparam int CDMA_CODE_WIDTH = 1 << LOG_CODE_WIDTH;
  localparam int COUNTER_WIDTH   = LOG_CODE_WIDTH;
  localparam int CHANNEL_WIDTH   = DATA_WIDTH + LOG_CODE_WIDTH;
  localparam int NUM_CODES       = 4;

  // Orthogonal Walsh codes; bit k of a code is the chip used at counter==k.
  localparam logic [CDMA_CODE_WIDTH-1:0] CDMA_CODES [NUM_CODES] = '{
    4'b0000,
    4'b1010,
    4'b1100,
    4'b0110
  };

  typedef enum logic {ENC_IDLE, ENC_RUN} enc_state_t;

endpackage

// File: rtl/cdma_frame_encoder_spreader.sv
// Combinational chip spreader: signed sum of every source word, each negated
// when its code bit for the current chip index is set.
module chip_spreader #(
  parameter int NUM_SRC        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int LOG_CODE_WIDTH = 2
) (
  input  logic [NUM_SRC*DATA_WIDTH-1:0]            data,
  input  logic [LOG_CODE_WIDTH-1:0]                chip,
  input  logic [NUM_SRC*(1<<LOG_CODE_WIDTH)-1:0]   codes,
  output logic [DATA_WIDTH+LOG_CODE_WIDTH-1:0]     sum
);

  localparam int CODE_WIDTH = 1 << LOG_CODE_WIDTH;
  localparam int SUM_WIDTH  = DATA_WIDTH + LOG_CODE_WIDTH;

  logic signed [SUM_WIDTH-1:0] signed_term [NUM_SRC];
  logic signed [SUM_WIDTH-1:0] acc;

  // Per-source term: sign-extend first so that negating the most negative word is exact.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [DATA_WIDTH-1:0]       word;
    logic [CODE_WIDTH-1:0]       code_word;
    logic signed [SUM_WIDTH-1:0] term;

    assign word      = data[g*DATA_WIDTH +: DATA_WIDTH];
    assign code_word = codes[g*CODE_WIDTH +: CODE_WIDTH];
    assign term      = {{LOG_CODE_WIDTH{word[DATA_WIDTH-1]}}, word};
    assign signed_term[g] = code_word[chip] ? -term : term;
  end

  // Accumulate all spread terms; the extra LOG_CODE_WIDTH bits absorb the growth.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      acc = acc + signed_term[i];
    end
  end

  assign sum = acc;

endmodule

// File: rtl/cdma_frame_encoder.sv
// CDMA frame encoder: latches one word per source at each frame boundary,
// drives the spread channel sum and the chip timing used by the decoders.
module cdma_frame_encoder
  import AggrCDMAPkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int DATA_WIDTH     = AggrCDMAPkg::DATA_WIDTH,
  parameter int LOG_CODE_WIDTH = AggrCDMAPkg::LOG_CODE_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic [NUM_SRC-1:0]                  in_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]       in_data,
  output logic [NUM_SRC-1:0]                  in_ready,
  output logic [LOG_CODE_WIDTH-1:0]           counter,
  output logic                                rotate_code,
  output logic [DATA_WIDTH+LOG_CODE_WIDTH-1:0] channel,
  output logic                                result_valid,
  output logic [NUM_SRC-1:0]                  result_mask
);

  localparam int CODE_WIDTH = 1 << LOG_CODE_WIDTH;
  localparam int CHAN_WIDTH = DATA_WIDTH + LOG_CODE_WIDTH;
  localparam logic [LOG_CODE_WIDTH-1:0] LAST_CHIP = '1;

  // Elaboration guards: every source needs its own code of the right length.
  if (NUM_SRC > $size(CDMA_CODES)) begin : g_num_src_check
    $error("cdma_frame_encoder: NUM_SRC exceeds the number of CDMA codes");
  end
  if (CODE_WIDTH != CDMA_CODE_WIDTH) begin : g_code_width_check
    $error("cdma_frame_encoder: LOG_CODE_WIDTH does not match the code table");
  end

  enc_state_t                       state;
  enc_state_t                       next_state;
  logic [LOG_CODE_WIDTH-1:0]        next_counter;
  logic [NUM_SRC*DATA_WIDTH-1:0]    data_q;
  logic [NUM_SRC*DATA_WIDTH-1:0]    next_data;
  logic [NUM_SRC*DATA_WIDTH-1:0]    latched_data;
  logic [NUM_SRC-1:0]               mask_q;
  logic [NUM_SRC-1:0]               next_mask;
  logic [NUM_SRC*CODE_WIDTH-1:0]    code_table;
  logic [CHAN_WIDTH-1:0]            spread_sum;
  logic                             accept;
  logic                             load;
  logic                             frame_end;

  // Absent sources are latched as zero so they add nothing to the channel.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_latch
    assign latched_data[g*DATA_WIDTH +: DATA_WIDTH] =
      in_valid[g] ? in_data[g*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign code_table[g*CODE_WIDTH +: CODE_WIDTH] = CDMA_CODES[g];
  end

  // Sources are accepted only while idle or on the last chip of a frame.
  assign in_ready = {NUM_SRC{accept}};

  // Next-state, next-counter and next-data decisions for the frame sequencer.
  always_comb begin
    accept       = enable && ((state == ENC_IDLE) || (counter == LAST_CHIP));
    load         = accept && (|in_valid);
    frame_end    = (state == ENC_RUN) && (counter == LAST_CHIP);
    next_state   = state;
    next_counter = counter;
    next_data    = data_q;
    next_mask    = mask_q;
    if ((state == ENC_RUN) && (counter != LAST_CHIP)) begin
      next_counter = counter + 1'b1;
    end else if (load) begin
      next_state   = ENC_RUN;
      next_counter = '0;
      next_data    = latched_data;
      next_mask    = in_valid;
    end else begin
      next_state   = ENC_IDLE;
      next_counter = LAST_CHIP;
    end
  end

  chip_spreader #(
    .NUM_SRC        (NUM_SRC),
    .DATA_WIDTH     (DATA_WIDTH),
    .LOG_CODE_WIDTH (LOG_CODE_WIDTH)
  ) u_spreader (
    .data  (next_data),
    .chip  (next_counter),
    .codes (code_table),
    .sum   (spread_sum)
  );

  // Frame FSM with registered outputs; channel is spread from next values so it lines up with counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ENC_IDLE;
      counter      <= LAST_CHIP;
      channel      <= '0;
      rotate_code  <= 1'b0;
      result_valid <= 1'b0;
      result_mask  <= '0;
      data_q       <= '0;
      mask_q       <= '0;
    end else begin
      state        <= next_state;
      counter      <= next_counter;
      channel      <= (next_state == ENC_RUN) ? spread_sum : '0;
      rotate_code  <= (next_state == ENC_RUN) && (next_counter != LAST_CHIP);
      result_valid <= frame_end;
      if (frame_end) begin
        result_mask <= mask_q;
      end
      data_q       <= next_data;
      mask_q       <= next_mask;
    end
  end

endmodule
